// File: rtl/diff_to_all_seq.sv
// diff_to_all_seq: sequential activation-derivative over LANES shared units (optional DIFF_TO_ALL_CHAIN_RULE_EN multiplies by err)
module diff_to_all_seq #(
   parameter int SIZE          = 3,
   parameter int DATA_SIZE     = 16,
   parameter int FRAC_BITS     = 8,
   parameter int ACT_TYPE_SIZE = 4,
   parameter int LANES         = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SIZE*DATA_SIZE-1:0]     x,
   input  logic [SIZE*ACT_TYPE_SIZE-1:0] act_type,
`ifdef DIFF_TO_ALL_CHAIN_RULE_EN
   input  logic [SIZE*DATA_SIZE-1:0]     err,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SIZE*DATA_SIZE-1:0]     diff,
   output logic                          busy
);
   localparam int PASSES = (SIZE + LANES - 1) / LANES;
   localparam int BW = $clog2(PASSES + 1);
   localparam int W2 = 2 * DATA_SIZE;
   localparam logic signed [DATA_SIZE-1:0] ONE = DATA_SIZE'(1 << FRAC_BITS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_n;
   logic [BW-1:0] beat;
   logic [SIZE*DATA_SIZE-1:0] x_r;
   logic [SIZE*ACT_TYPE_SIZE-1:0] at_r;
   logic cv, done_now;
   int lane_e [LANES];
   logic lane_on [LANES];
   logic signed [DATA_SIZE-1:0] lane_val [LANES];
   int wr_e [LANES];
   logic wr_on [LANES];
   logic signed [DATA_SIZE-1:0] wr_val [LANES];

   function automatic logic signed [DATA_SIZE-1:0] gdo_diff_linear();
      return ONE;
   endfunction

   function automatic logic signed [DATA_SIZE-1:0] gdo_diff_binary();
      return '0;
   endfunction

   // hard sigmoid s = clamp(0.5 + v/4, 0, 1); derivative s*(1-s)
   function automatic logic signed [DATA_SIZE-1:0] gdo_diff_sigmoid(input logic signed [DATA_SIZE-1:0] v);
      logic signed [W2-1:0] s, p;
      s = W2'(ONE >>> 1) + W2'(v >>> 2);
      s = s[W2-1] ? '0 : (s > W2'(ONE) ? W2'(ONE) : s);
      p = s * (W2'(ONE) - s);
      return DATA_SIZE'(p >>> FRAC_BITS);
   endfunction

   // hard tanh t = clamp(v, -1, 1); derivative 1 - t*t
   function automatic logic signed [DATA_SIZE-1:0] gdo_diff_tanh(input logic signed [DATA_SIZE-1:0] v);
      logic signed [W2-1:0] t, p;
      t = W2'(v);
      t = t < -W2'(ONE) ? -W2'(ONE) : (t > W2'(ONE) ? W2'(ONE) : t);
      p = t * t;
      return DATA_SIZE'(W2'(ONE) - (p >>> FRAC_BITS));
   endfunction

   function automatic logic signed [DATA_SIZE-1:0] lane_diff(input logic [ACT_TYPE_SIZE-1:0] c, input logic signed [DATA_SIZE-1:0] v);
      return c == ACT_TYPE_SIZE'(1) ? gdo_diff_binary() :
             c == ACT_TYPE_SIZE'(2) ? gdo_diff_sigmoid(v) :
             c == ACT_TYPE_SIZE'(3) ? gdo_diff_tanh(v) : gdo_diff_linear();
   endfunction

`ifdef DIFF_TO_ALL_CHAIN_RULE_EN
   localparam logic signed [W2-1:0] SMAX = W2'({1'b0, {(DATA_SIZE-1){1'b1}}});
   localparam logic signed [W2-1:0] SMIN = ~SMAX;

   logic [SIZE*DATA_SIZE-1:0] err_r;
   logic pipe_on [LANES];
   int pipe_e [LANES];
   logic signed [DATA_SIZE-1:0] pipe_val [LANES];
   logic pipe_last;

   function automatic logic signed [DATA_SIZE-1:0] gdo_chain(input logic signed [DATA_SIZE-1:0] d, input logic signed [DATA_SIZE-1:0] g);
      logic signed [W2-1:0] p;
      p = (W2'(d) * W2'(g)) >>> FRAC_BITS;
      return p > SMAX ? DATA_SIZE'(SMAX) : (p < SMIN ? DATA_SIZE'(SMIN) : DATA_SIZE'(p));
   endfunction

   // err is captured alongside x so the chain-rule product sees the same vector
   always_ff @(posedge clk or posedge reset)
      if (reset) err_r <= '0;
      else if (state == IDLE && in_valid) err_r <= err;

   // one extra register stage per lane between product and diff
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_last <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            pipe_on[l] <= 1'b0;
            pipe_e[l] <= 0;
            pipe_val[l] <= '0;
         end
      end else begin
         pipe_last <= cv && beat == BW'(PASSES - 1);
         for (int l = 0; l < LANES; l++) begin
            pipe_on[l] <= lane_on[l];
            pipe_e[l] <= lane_e[l];
            pipe_val[l] <= lane_val[l];
         end
      end
   end

   // diff is written from the pipeline stage, completion follows it
   always_comb begin
      wr_on = pipe_on;
      wr_e = pipe_e;
      wr_val = pipe_val;
      done_now = pipe_last;
   end
`else
   // diff is written straight from the lanes
   always_comb begin
      wr_on = lane_on;
      wr_e = lane_e;
      wr_val = lane_val;
      done_now = cv && beat == BW'(PASSES - 1);
   end
`endif

   // per-lane element selection and derivative for the current beat
   always_comb begin
      cv = state == BUSY && beat < BW'(PASSES);
      for (int l = 0; l < LANES; l++) begin
         lane_e[l] = int'(beat) * LANES + l;
         lane_on[l] = cv && lane_e[l] < SIZE;
         lane_val[l] = '0;
         if (lane_e[l] < SIZE)
`ifdef DIFF_TO_ALL_CHAIN_RULE_EN
            lane_val[l] = gdo_chain(lane_diff(at_r[lane_e[l]*ACT_TYPE_SIZE +: ACT_TYPE_SIZE], x_r[lane_e[l]*DATA_SIZE +: DATA_SIZE]),
                                    err_r[lane_e[l]*DATA_SIZE +: DATA_SIZE]);
`else
            lane_val[l] = lane_diff(at_r[lane_e[l]*ACT_TYPE_SIZE +: ACT_TYPE_SIZE], x_r[lane_e[l]*DATA_SIZE +: DATA_SIZE]);
`endif
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   // next state and handshake outputs
   always_comb begin
      state_n = state;
      in_ready = state == IDLE;
      busy = state == BUSY;
      out_valid = state == DONE;
      if (state == IDLE && in_valid) state_n = BUSY;
      if (state == BUSY && done_now) state_n = DONE;
      if (state == DONE && out_ready) state_n = IDLE;
   end

   // capture, beat counting and result writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r <= '0;
         at_r <= '0;
         beat <= '0;
         diff <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            x_r <= x;
            at_r <= act_type;
            beat <= '0;
         end else if (cv) beat <= beat + BW'(1);
         for (int l = 0; l < LANES; l++)
            if (wr_on[l]) diff[wr_e[l]*DATA_SIZE +: DATA_SIZE] <= wr_val[l];
      end
   end
endmodule

// File: tb/tb_diff_to_all_seq.sv
// tb_diff_to_all_seq: randomized self-checking bench for two diff_to_all_seq configurations
module tb_diff_to_all_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
   logic [47:0] a_x = '0, a_diff;
   logic [11:0] a_at = '0;
   logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
   logic [79:0] b_x = '0, b_diff;
   logic [19:0] b_at = '0;
   int checks = 0, errors = 0;

   diff_to_all_seq #(.SIZE(3), .DATA_SIZE(16), .FRAC_BITS(8), .ACT_TYPE_SIZE(4), .LANES(1)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x), .act_type(a_at),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .diff(a_diff), .busy(a_busy));

   diff_to_all_seq #(.SIZE(5), .DATA_SIZE(16), .FRAC_BITS(8), .ACT_TYPE_SIZE(4), .LANES(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .act_type(b_at),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .diff(b_diff), .busy(b_busy));

   // derivative of one element in Q8.8: linear 1.0, binary 0, hard sigmoid s(1-s), hard tanh 1-t^2
   function automatic int ref_d(input int c, input int v);
      int s, t;
      case (c)
         1: return 0;
         2: begin
            s = 128 + (v >>> 2);
            s = s < 0 ? 0 : (s > 256 ? 256 : s);
            return s * (256 - s) / 256;
         end
         3: begin
            t = v < -256 ? -256 : (v > 256 ? 256 : v);
            return 256 - t * t / 256;
         end
         default: return 256;
      endcase
   endfunction

   function automatic logic [79:0] model(input logic [79:0] xv, input logic [19:0] tv, input int n);
      logic [79:0] r = '0;
      for (int i = 0; i < n; i++) r[i*16 +: 16] = 16'(ref_d(int'(tv[i*4 +: 4]), int'($signed(xv[i*16 +: 16]))));
      return r;
   endfunction

   task automatic run_a(input logic [47:0] xv, input logic [11:0] tv, input string nm);
      int lat = 0;
      logic [79:0] e;
      e = model(80'(xv), 20'(tv), 3);
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", nm, a_in_ready); end
      a_x = xv; a_at = tv; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_x = 48'({$urandom(), $urandom()}); a_at = 12'($urandom());
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", nm, a_busy); end
      while (a_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 3) begin errors++; $display("FAIL %s_latency got %0d want 3", nm, lat); end
      checks++; if (a_diff !== e[47:0]) begin errors++; $display("FAIL %s_diff got %h want %h", nm, a_diff, e[47:0]); end
      a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
      checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL %s_release got ov=%b ir=%b want 0 1", nm, a_out_valid, a_in_ready); end
   endtask

   task automatic run_b(input logic [79:0] xv, input logic [19:0] tv, input string nm);
      int lat = 0;
      logic [79:0] e;
      e = model(xv, tv, 5);
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", nm, b_in_ready); end
      b_x = xv; b_at = tv; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_x = 80'({$urandom(), $urandom(), $urandom()}); b_at = 20'($urandom());
      while (b_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 3) begin errors++; $display("FAIL %s_latency got %0d want 3", nm, lat); end
      checks++; if (b_diff !== e) begin errors++; $display("FAIL %s_diff got %h want %h", nm, b_diff, e); end
      b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
      checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL %s_release got ov=%b ir=%b want 0 1", nm, b_out_valid, b_in_ready); end
   endtask

   task automatic test_reset;
      int lat = 0;
      #1;
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_diff !== '0)
         begin errors++; $display("FAIL reset_a got ir=%b ov=%b bz=%b d=%h want 1 0 0 0", a_in_ready, a_out_valid, a_busy, a_diff); end
      checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_diff !== '0)
         begin errors++; $display("FAIL reset_b got ir=%b ov=%b bz=%b d=%h want 1 0 0 0", b_in_ready, b_out_valid, b_busy, b_diff); end
      @(negedge clk); reset = 1'b0;
      a_x = 48'h0300_0200_0100; a_at = 12'h000; a_in_valid = 1'b1;
      @(posedge clk); #1; a_in_valid = 1'b0;
      while (a_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      #2 reset = 1'b1; #1;
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_diff !== '0)
         begin errors++; $display("FAIL reset_done got ir=%b ov=%b bz=%b d=%h want 1 0 0 0", a_in_ready, a_out_valid, a_busy, a_diff); end
      @(negedge clk); reset = 1'b0;
      a_in_valid = 1'b1;
      @(posedge clk); #1; a_in_valid = 1'b0;
      @(posedge clk); #2 reset = 1'b1; #1;
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_diff !== '0)
         begin errors++; $display("FAIL reset_busy got ir=%b ov=%b bz=%b d=%h want 1 0 0 0", a_in_ready, a_out_valid, a_busy, a_diff); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_directed;
      run_a({16'hFF00, 16'h0200, 16'h0100}, 12'h000, "linear");
      run_a({16'h1234, 16'h8000, 16'h7FFF}, {4'd7, 4'd0, 4'd1}, "mixed");
      run_a({16'h0180, 16'h0080, 16'h0000}, {4'd2, 4'd3, 4'd3}, "curves");
   endtask

   task automatic test_partial;
      run_b({16'hFE80, 16'h0180, 16'hFE80, 16'h0180, 16'h0000}, {4'd3, 4'd3, 4'd2, 4'd2, 4'd2}, "partial0");
      run_b({16'h0000, 16'h0000, 16'h0180, 16'h0000, 16'hFE80}, {4'd2, 4'd2, 4'd3, 4'd3, 4'd3}, "partial1");
   endtask

   task automatic test_random;
      logic [79:0] xv;
      logic [19:0] tv;
      for (int n = 0; n < 12; n++) run_a(48'({$urandom(), $urandom()}), 12'($urandom()), "rand_a");
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 5; i++) begin
            xv[i*16 +: 16] = 16'($urandom_range(0, 1024)) - 16'd512;
            tv[i*4 +: 4] = 4'($urandom_range(0, 4));
         end
         run_b(xv, tv, "rand_b");
      end
   endtask

   task automatic test_backpressure;
      logic [79:0] e1, e2;
      int lat = 0;
      e1 = model(80'({16'h0180, 16'h0080, 16'h0000}), 20'({4'd2, 4'd3, 4'd3}), 3);
      e2 = model(80'({16'h0100, 16'h0100, 16'h0100}), 20'({4'd0, 4'd1, 4'd0}), 3);
      a_x = {16'h0180, 16'h0080, 16'h0000}; a_at = {4'd2, 4'd3, 4'd3}; a_in_valid = 1'b1;
      @(posedge clk); #1; a_in_valid = 1'b0;
      while (a_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      a_x = {16'h0100, 16'h0100, 16'h0100}; a_at = {4'd0, 4'd1, 4'd0}; a_in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         checks++; if (a_diff !== e1[47:0] || a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
            begin errors++; $display("FAIL hold got d=%h ir=%b ov=%b want %h 0 1", a_diff, a_in_ready, a_out_valid, e1[47:0]); end
      end
      a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0)
         begin errors++; $display("FAIL bp_idle got ir=%b ov=%b bz=%b want 1 0 0", a_in_ready, a_out_valid, a_busy); end
      @(posedge clk); #1; a_in_valid = 1'b0;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL bp_capture got bz=%b want 1", a_busy); end
      lat = 0;
      while (a_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 3 || a_diff !== e2[47:0]) begin errors++; $display("FAIL bp_second got lat=%0d d=%h want 3 %h", lat, a_diff, e2[47:0]); end
      a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [79:0] e;
      e = model(80'({16'h0040, 16'hFF00, 16'h0100}), 20'({4'd3, 4'd2, 4'd3}), 3);
      a_x = {16'h0040, 16'hFF00, 16'h0100}; a_at = {4'd3, 4'd2, 4'd3};
      a_out_ready = 1'b1; a_in_valid = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         checks++; if (a_out_valid !== ((n - 1) % 5 == 3)) begin errors++; $display("FAIL b2b_valid edge %0d got %b want %b", n, a_out_valid, (n - 1) % 5 == 3); end
         if ((n - 1) % 5 == 3) begin
            checks++; if (a_diff !== e[47:0]) begin errors++; $display("FAIL b2b_diff got %h want %h", a_diff, e[47:0]); end
         end
      end
      a_in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 a_out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_partial();
      test_random();
      test_backpressure();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
